servo_profile_ctrl: RTL



---
 rtl/servo_profile_ctrl.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/servo_profile_ctrl.sv
// Servo position controller: ramps a PWM duty ratio toward a target with an accel/cruise/decel profile.
// Optional ratio clamping and limit_hit output when SERVO_RATIO_LIMIT_EN is defined.
module servo_profile_ctrl #(
  parameter int unsigned RATIO_W        = 8,
  parameter int unsigned PROFILE_DEPTH  = 8,
  parameter int unsigned MIN_DELAY      = 24,
  parameter int unsigned DELAY_STEP     = 16,
  parameter int unsigned SETTLE_PERIODS = 32,
  parameter int unsigned DELAY_W        = 10
`ifdef SERVO_RATIO_LIMIT_EN
  ,
  parameter int unsigned MIN_RATIO      = 'h10,
  parameter int unsigned MAX_RATIO      = 'hF0
`endif
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               pwm_enable,
  input  logic [RATIO_W-1:0] start_ratio,
  input  logic [RATIO_W-1:0] target_ratio,
  output logic               pwm_signal,
  output logic [RATIO_W-1:0] curr_ratio,
  output logic               busy,
  output logic               at_target,
`ifdef SERVO_RATIO_LIMIT_EN
  output logic               limit_hit,
`endif
  output logic               period_tick
);

  localparam int unsigned STEP_W = $clog2(PROFILE_DEPTH);
  localparam int unsigned SET_W  = $clog2(SETTLE_PERIODS + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_HOLD   = 2'd2;
  localparam logic [1:0] S_MOVE   = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [RATIO_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [RATIO_W-1:0] duty_q, duty_d;
  logic [RATIO_W-1:0] curr_q, curr_d;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic               dir_q, dir_d;
  logic [DELAY_W-1:0] delay_q, delay_d;

  logic [RATIO_W-1:0] raw_target, eff_target, next_ratio, remain;
  logic [STEP_W-1:0]  step_next;
  logic               tick, want_up;

  function automatic logic [DELAY_W-1:0] delay_of(input logic [STEP_W-1:0] k);
    return DELAY_W'(MIN_DELAY + (PROFILE_DEPTH - 1 - 32'(k)) * DELAY_STEP);
  endfunction

  assign raw_target = (target_ratio == '0) ? start_ratio : target_ratio;

`ifdef SERVO_RATIO_LIMIT_EN
  localparam logic [RATIO_W-1:0] MIN_R = RATIO_W'(MIN_RATIO);
  localparam logic [RATIO_W-1:0] MAX_R = RATIO_W'(MAX_RATIO);
  logic clamp_active;

  always_comb begin
    eff_target   = raw_target;
    clamp_active = 1'b0;
    if (raw_target < MIN_R) begin
      eff_target   = MIN_R;
      clamp_active = 1'b1;
    end else if (raw_target > MAX_R) begin
      eff_target   = MAX_R;
      clamp_active = 1'b1;
    end
  end

  assign limit_hit = clamp_active && (state_q != S_IDLE);
`else
  assign eff_target = raw_target;
`endif

  assign tick       = &pwm_cnt_q;
  assign want_up    = eff_target > curr_q;
  assign next_ratio = dir_q ? curr_q + RATIO_W'(1) : curr_q - RATIO_W'(1);
  assign remain     = dir_q ? eff_target - next_ratio : next_ratio - eff_target;

  // Speed step after a unit move: accelerate, cap at top speed, and never exceed
  // remaining distance minus one so the final unit is always taken at step 0.
  always_comb begin
    step_next = (step_q == STEP_W'(PROFILE_DEPTH - 1)) ? step_q : step_q + STEP_W'(1);
    if (32'(step_next) >= 32'(remain) && remain != '0)
      step_next = STEP_W'(remain - RATIO_W'(1));
  end

  always_comb begin
    state_d   = state_q;
    pwm_cnt_d = pwm_cnt_q;
    duty_d    = duty_q;
    curr_d    = curr_q;
    settle_d  = settle_q;
    step_d    = step_q;
    dir_d     = dir_q;
    delay_d   = delay_q;
    if (!pwm_enable) begin
      state_d   = S_IDLE;
      pwm_cnt_d = '0;
      duty_d    = '0;
      settle_d  = '0;
      step_d    = '0;
      delay_d   = '0;
    end else begin
      pwm_cnt_d = (state_q == S_IDLE) ? '0 : pwm_cnt_q + RATIO_W'(1);
      if (tick) duty_d = curr_q;
      case (state_q)
        S_IDLE: begin
          curr_d   = start_ratio;
          settle_d = '0;
          state_d  = S_SETTLE;
        end
        S_SETTLE: begin
          if (tick) begin
            if (settle_q == SET_W'(SETTLE_PERIODS - 1)) begin
              settle_d = '0;
              state_d  = S_HOLD;
            end else begin
              settle_d = settle_q + SET_W'(1);
            end
          end
        end
        S_HOLD: begin
          if (curr_q != eff_target) begin
            state_d = S_MOVE;
            step_d  = '0;
            dir_d   = want_up;
            delay_d = '0;
          end
        end
        default: begin
          if (tick) begin
            if (delay_q + DELAY_W'(1) == delay_of(step_q)) begin
              delay_d = '0;
              // Target is re-evaluated before committing a unit: reached or
              // reversed targets are handled without stepping past curr_ratio.
              if (eff_target == curr_q) begin
                state_d = S_HOLD;
                step_d  = '0;
              end else if (want_up != dir_q) begin
                dir_d  = want_up;
                step_d = '0;
              end else begin
                curr_d = next_ratio;
                if (remain == '0) begin
                  state_d = S_HOLD;
                  step_d  = '0;
                end else begin
                  step_d = step_next;
                end
              end
            end else begin
              delay_d = delay_q + DELAY_W'(1);
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      pwm_cnt_q <= '0;
      duty_q    <= '0;
      curr_q    <= '0;
      settle_q  <= '0;
      step_q    <= '0;
      dir_q     <= 1'b0;
      delay_q   <= '0;
    end else begin
      state_q   <= state_d;
      pwm_cnt_q <= pwm_cnt_d;
      duty_q    <= duty_d;
      curr_q    <= curr_d;
      settle_q  <= settle_d;
      step_q    <= step_d;
      dir_q     <= dir_d;
      delay_q   <= delay_d;
    end
  end

  assign pwm_signal  = pwm_cnt_q < duty_q;
  assign curr_ratio  = curr_q;
  assign busy        = (state_q == S_MOVE);
  assign at_target   = (state_q == S_HOLD) && (curr_q == eff_target);
  assign period_tick = tick;

endmodule
